// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one four-bank main memory between the I-cache controller and the
//   D-cache controller. A side owns the memory for a whole burst (held by its
//   req). The owner's strobes, address and data are passed straight to memory.
//   Every read that memory accepts is tagged with its issuing side, so the
//   returned data is steered back to that side RD_LAT cycles later.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   i_req/i_rd/i_wr          I side ownership request and strobes
//   i_addr/i_data_in         I side address and write data
//   i_gnt/i_stall            I side ownership and hold-off
//   i_data_out/i_data_vld    read data steered to the I side
//   d_*                      same set for the D side
//   mem_rd/mem_wr            memory strobes (owner's, conflict-filtered)
//   mem_addr/mem_data_in     memory address and write data
//   mem_data_out             memory read data (valid RD_LAT after mem_rd)
//   mem_busy[3:0]            per-bank busy, drained before re-arbitration
//   mem_stall                memory rejects this cycle's access
//   err                      sticky: rd+wr conflict or starvation limit hit
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data_in,
    output logic              i_gnt,
    output logic              i_stall,
    output logic [DATA_W-1:0] i_data_out,
    output logic              i_data_vld,
    input  logic              d_req,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data_in,
    output logic              d_gnt,
    output logic              d_stall,
    output logic [DATA_W-1:0] d_data_out,
    output logic              d_data_vld,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic [3:0]        mem_busy,
    input  logic              mem_stall,
    output logic              err
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN_I = 2'd1,
        S_OWN_D = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_d;     // 1: D was the last owner
    logic [HOLD_W-1:0]   r_hold;
    logic                r_err;
    logic [RD_LAT-1:0]   r_tag_vld;    // [0] newest, [RD_LAT-1] returns now
    logic [RD_LAT-1:0]   r_tag_d;      // issuing side of each tag, 1 = D

    logic                w_own_i;
    logic                w_own_d;
    logic                w_leaving;
    logic                w_waiting;
    logic                w_drain_done;
    logic                w_rd;
    logic                w_wr;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_conflict;
    logic                w_push;

    assign w_own_i      = (r_state == S_OWN_I);
    assign w_own_d      = (r_state == S_OWN_D);
    assign w_drain_done = ~(|r_tag_vld) & (mem_busy == 4'b0000);
    assign w_leaving    = (w_own_i | w_own_d) & (w_state_nxt != r_state);
    assign w_waiting    = (w_own_i & d_req) | (w_own_d & i_req);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // Tie goes to the side that did not own last.
                if (i_req && d_req) w_state_nxt = r_last_d ? S_OWN_I : S_OWN_D;
                else if (i_req)     w_state_nxt = S_OWN_I;
                else if (d_req)     w_state_nxt = S_OWN_D;
            end
            S_OWN_I: if (!i_req) w_state_nxt = S_DRAIN;
            S_OWN_D: if (!d_req) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        // Grant drops in the same cycle the owner's req is seen low.
        i_gnt   = w_own_i & i_req;
        d_gnt   = w_own_d & d_req;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (i_gnt) begin
            w_rd    = i_rd;
            w_wr    = i_wr;
            w_addr  = i_addr;
            w_wdata = i_data_in;
        end else if (d_gnt) begin
            w_rd    = d_rd;
            w_wr    = d_wr;
            w_addr  = d_addr;
            w_wdata = d_data_in;
        end
        w_conflict  = w_rd & w_wr;
        mem_rd      = w_rd & ~w_wr;
        mem_wr      = w_wr & ~w_rd;
        mem_addr    = w_addr;
        mem_data_in = w_wdata;
        // Gated by rst so a req held during reset does not show a stall.
        i_stall     = rst & i_req & (~i_gnt | mem_stall);
        d_stall     = rst & d_req & (~d_gnt | mem_stall);
    end

    // A stalled strobe is re-driven next cycle, so only accepted reads get a tag.
    assign w_push = mem_rd & ~mem_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= '0;
            r_tag_d   <= '0;
        end else begin
            for (int k = RD_LAT - 1; k > 0; k--) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_d[k]   <= r_tag_d[k-1];
            end
            r_tag_vld[0] <= w_push;
            r_tag_d[0]   <= w_own_d;
        end
    end

    assign i_data_vld = r_tag_vld[RD_LAT-1] & ~r_tag_d[RD_LAT-1];
    assign d_data_vld = r_tag_vld[RD_LAT-1] &  r_tag_d[RD_LAT-1];
    assign i_data_out = i_data_vld ? mem_data_out : '0;
    assign d_data_out = d_data_vld ? mem_data_out : '0;

    // ---------------- arbitration history / starvation ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d <= 1'b0;
            r_hold   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_leaving) r_last_d <= w_own_d;

            if (!(w_own_i || w_own_d) || w_leaving)
                r_hold <= '0;
            else if (w_waiting && r_hold != HOLD_MAX)
                r_hold <= r_hold + HOLD_W'(1);

            r_err <= r_err | w_conflict | (r_hold == HOLD_MAX);
        end
    end

    assign err = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req, i_rd, i_wr, d_req, d_rd, d_wr;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_data_in, d_data_in, i_data_out, d_data_out;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic          i_gnt, i_stall, i_data_vld, d_gnt, d_stall, d_data_vld;
    logic          mem_rd, mem_wr, mem_stall, err;
    logic [3:0]    mem_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_HOLD(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_data_in(i_data_in),
        .i_gnt(i_gnt), .i_stall(i_stall), .i_data_out(i_data_out), .i_data_vld(i_data_vld),
        .d_req(d_req), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
        .d_gnt(d_gnt), .d_stall(d_stall), .d_data_out(d_data_out), .d_data_vld(d_data_vld),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_busy(mem_busy), .mem_stall(mem_stall), .err(err)
    );

    // Memory: accepted read of addr returns 0xA0 + addr[3:1] RL cycles later,
    // otherwise the bus carries 0xDEAD.
    logic [DW-1:0] mq [RL];
    always @(posedge clk) begin
        mq[0] <= (mem_rd && !mem_stall) ? (16'h00A0 + {13'd0, mem_addr[3:1]}) : 16'hDEAD;
        for (int i = 1; i < RL; i++) mq[i] <= mq[i-1];
    end
    assign mem_data_out = mq[RL-1];

    wire [8:0] outs = {i_gnt, i_stall, i_data_vld, d_gnt, d_stall, d_data_vld, mem_rd, mem_wr, err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        i_req = 0; i_rd = 0; i_wr = 0; i_addr = '0; i_data_in = '0;
        d_req = 0; d_rd = 0; d_wr = 0; d_addr = '0; d_data_in = '0;
        mem_stall = 0; mem_busy = 4'b0000;
    endtask

    // Release everything and let DRAIN finish back into IDLE.
    task automatic settle();
        clr_in();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        clr_in();
        i_req = 1; d_req = 1;
        // ---- reset ----
        @(negedge clk); #1;
        chk("rst_outs", 32'(outs), 32'h0);
        chk("rst_data", {i_data_out, d_data_out}, 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        @(negedge clk); rst = 1; clr_in();

        // ---- single I burst ----
        @(negedge clk); i_req = 1; #1;
        chk("t1_gnt_lat", 32'(i_gnt), 32'h0);
        chk("t1_stall_wait", 32'(i_stall), 32'h1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            i_rd = (k < 4); i_addr = 16'(16'h0100 + 2 * k); #1;
            chk("t1_gnt", 32'(i_gnt), 32'h1);
            chk("t1_mrd", 32'(mem_rd), 32'(k < 4));
            if (k < 4) chk("t1_addr", 32'(mem_addr), 32'(16'h0100 + 2 * k));
            chk("t1_ivld", 32'(i_data_vld), 32'(k >= 2));
            chk("t1_idat", 32'(i_data_out), (k >= 2) ? 32'(16'h00A0 + k - 2) : 32'h0);
            chk("t1_dvld", 32'(d_data_vld), 32'h0);
        end
        @(negedge clk); i_rd = 0; i_req = 0; #1;
        chk("t1_rel_gnt", 32'(i_gnt), 32'h0);
        repeat (2) @(negedge clk);

        // ---- tie arbitration ----
        @(negedge clk); i_req = 1; d_req = 1; #1;
        chk("t2_nogrant", 32'({i_gnt, d_gnt}), 32'h0);
        @(negedge clk); #1;
        chk("t2_d_first", 32'({i_gnt, d_gnt}), 32'h1);
        chk("t2_istall", 32'(i_stall), 32'h1);
        @(negedge clk); d_req = 0; #1;
        chk("t2_drel", 32'({i_gnt, d_gnt}), 32'h0);
        @(negedge clk); #1;
        chk("t2_drain", 32'(i_gnt), 32'h0);
        @(negedge clk); #1;
        chk("t2_idle", 32'(i_gnt), 32'h0);
        @(negedge clk); #1;
        chk("t2_i_next", 32'({i_gnt, d_gnt}), 32'h2);
        @(negedge clk); i_req = 0;
        @(negedge clk);
        @(negedge clk); i_req = 1; d_req = 1;
        @(negedge clk); #1;
        chk("t2_tie2_d", 32'({i_gnt, d_gnt}), 32'h1);
        settle();

        // ---- D writeback then fill, I waiting ----
        @(negedge clk); d_req = 1;
        @(negedge clk); i_req = 1; #1;
        chk("t3_dgnt", 32'(d_gnt), 32'h1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            d_wr = (k < 4); d_rd = (k >= 4 && k < 8);
            d_addr = 16'(16'h0200 + 2 * k); d_data_in = 16'(16'h5550 + k);
            i_rd = 1; i_addr = 16'hFFFE; #1;
            chk("t3_mwr", 32'(mem_wr), 32'(k < 4));
            chk("t3_mrd", 32'(mem_rd), 32'(k >= 4 && k < 8));
            if (k < 8) chk("t3_addr", 32'(mem_addr), 32'(16'h0200 + 2 * k));
            if (k < 4) chk("t3_wdat", 32'(mem_data_in), 32'(16'h5550 + k));
            chk("t3_istall", 32'(i_stall), 32'h1);
            chk("t3_dvld", 32'(d_data_vld), 32'(k >= 6));
            if (k >= 6) chk("t3_ddat", 32'(d_data_out), 32'(16'h00A4 + k - 6));
            chk("t3_ivld", 32'(i_data_vld), 32'h0);
            chk("t3_err", 32'(err), 32'h0);
        end
        @(negedge clk); d_req = 0; d_rd = 0; d_wr = 0; i_rd = 0; #1;
        chk("t3_drel", 32'(d_gnt), 32'h0);
        repeat (2) @(negedge clk);
        @(negedge clk); #1;
        chk("t3_igrant", 32'(i_gnt), 32'h1);
        chk("t3_err_end", 32'(err), 32'h0);
        settle();

        // ---- memory stall during D read ----
        @(negedge clk); d_req = 1;
        @(negedge clk); #1;
        chk("t4_dgnt", 32'(d_gnt), 32'h1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            d_rd = (k < 4); d_addr = 16'h020A; mem_stall = (k < 3); #1;
            chk("t4_dstall", 32'(d_stall), 32'(k < 3));
            chk("t4_mrd", 32'(mem_rd), 32'(k < 4));
            chk("t4_dvld", 32'(d_data_vld), 32'(k == 5));
            if (k == 5) chk("t4_ddat", 32'(d_data_out), 32'h00A5);
        end
        settle();

        // ---- DRAIN held by mem_busy; D raises as I drops ----
        @(negedge clk); i_req = 1;
        @(negedge clk); #1;
        chk("t5_igrant", 32'(i_gnt), 32'h1);
        @(negedge clk); i_req = 0; d_req = 1; mem_busy = 4'b0010; #1;
        chk("t5_rel", 32'({i_gnt, d_gnt}), 32'h0);
        @(negedge clk); #1; chk("t5_busy1", 32'(d_gnt), 32'h0);
        @(negedge clk); #1; chk("t5_busy2", 32'(d_gnt), 32'h0);
        @(negedge clk); mem_busy = 4'b0000; #1; chk("t5_free", 32'(d_gnt), 32'h0);
        @(negedge clk); #1;
        chk("t5_idle", 32'(d_gnt), 32'h0);
        chk("t5_dstall", 32'(d_stall), 32'h1);
        @(negedge clk); #1; chk("t5_dgnt", 32'(d_gnt), 32'h1);
        settle();

        // ---- rd+wr conflict ----
        @(negedge clk); i_req = 1;
        @(negedge clk); #1; chk("t6_igrant", 32'(i_gnt), 32'h1);
        @(negedge clk); i_rd = 1; i_wr = 1; #1;
        chk("t6_nostrobe", 32'({mem_rd, mem_wr}), 32'h0);
        chk("t6_err_pre", 32'(err), 32'h0);
        @(negedge clk); i_rd = 0; i_wr = 0; #1;
        chk("t6_err_set", 32'(err), 32'h1);
        settle();
        chk("t6_err_sticky", 32'(err), 32'h1);

        // ---- reset mid-burst with a read in flight ----
        @(negedge clk); i_req = 1;
        @(negedge clk); #1; chk("t7_igrant", 32'(i_gnt), 32'h1);
        @(negedge clk); i_rd = 1; i_addr = 16'h0100; #1;
        chk("t7_mrd", 32'(mem_rd), 32'h1);
        @(negedge clk); i_rd = 0; rst = 0; #1;
        chk("t7_rst_outs", 32'(outs), 32'h0);
        chk("t7_rst_addr", 32'(mem_addr), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); rst = 1; clr_in(); #1;
            chk("t7_no_vld", 32'({i_data_vld, d_data_vld}), 32'h0);
            chk("t7_no_dat", 32'(i_data_out), 32'h0);
        end

        // ---- starvation limit ----
        @(negedge clk); d_req = 1;
        @(negedge clk); i_req = 1; #1;
        chk("t8_dgnt", 32'(d_gnt), 32'h1);
        repeat (15) @(negedge clk);
        #1 chk("t8_err_early", 32'(err), 32'h0);
        repeat (3) @(negedge clk);
        #1 chk("t8_err_set", 32'(err), 32'h1);
        chk("t8_gnt_kept", 32'(d_gnt), 32'h1);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
